// File: rtl/memory_port_arbiter_pkg.sv
// memory_port_arbiter_pkg: read-owner encoding, default widths and owner helper
package memory_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

    localparam int DEF_ADDR_WIDTH   = 14;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_CNT_WIDTH    = 3;

    function automatic owner_e read_owner(input logic cpu_gnt, input logic cpu_we,
                                          input logic aux_gnt, input logic aux_we);
        return (cpu_gnt && !cpu_we) ? OWN_CPU : (aux_gnt && !aux_we) ? OWN_AUX : OWN_NONE;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of aux denials; clear beats freeze beats increment
module arb_starve_counter #(
    parameter int LIMIT     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_freeze,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_sat
);

    localparam logic [CNT_WIDTH-1:0] L_MAX = CNT_WIDTH'(LIMIT);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_inc && !i_freeze && r_cnt != L_MAX)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
    assign o_sat = (r_cnt == L_MAX);

endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory data port between CPU and an aux master,
// CPU priority with aux starvation protection, CPU lock for RMW, 1-cycle read return.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic                  i_cpu_lock,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_gnt,
    output logic                  o_cpu_rvalid,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_stall,
    input  logic                  i_aux_req,
    input  logic                  i_aux_we,
    input  logic [ADDR_WIDTH-1:0] i_aux_addr,
    input  logic [DATA_WIDTH-1:0] i_aux_wdata,
    output logic                  o_aux_gnt,
    output logic                  o_aux_rvalid,
    output logic [DATA_WIDTH-1:0] o_aux_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    logic                  r_locked;
    owner_e                r_rd_owner;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_aux_rdata;
    logic                  w_sat;
    logic                  w_cpu_gnt;
    logic                  w_aux_gnt;
    logic [CNT_WIDTH-1:0]  w_cnt;

    // Grants are gated by reset so nothing reaches memory while reset is held.
    assign w_cpu_gnt = i_rst_n && i_cpu_req && (r_locked || !(i_aux_req && w_sat));
    assign w_aux_gnt = i_rst_n && !r_locked && i_aux_req && (w_sat || !i_cpu_req);

    arb_starve_counter #(
        .LIMIT     (STARVE_LIMIT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_starve (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_aux_gnt || !i_aux_req),
        .i_freeze (r_locked),
        .i_inc    (i_aux_req && !w_aux_gnt),
        .o_cnt    (w_cnt),
        .o_sat    (w_sat)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_locked <= 1'b0;
        else if (!i_cpu_req)
            r_locked <= 1'b0;
        else if (w_cpu_gnt)
            r_locked <= i_cpu_lock;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rd_owner <= OWN_NONE;
        else
            r_rd_owner <= read_owner(w_cpu_gnt, i_cpu_we, w_aux_gnt, i_aux_we);
    end

    // Returned data passes straight through on rvalid and is held afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cpu_rdata <= '0;
            r_aux_rdata <= '0;
        end else begin
            if (r_rd_owner == OWN_CPU)
                r_cpu_rdata <= i_mem_rdata;
            if (r_rd_owner == OWN_AUX)
                r_aux_rdata <= i_mem_rdata;
        end
    end

    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_aux_gnt    = w_aux_gnt;
    assign o_cpu_stall  = i_cpu_req && !w_cpu_gnt;
    assign o_cpu_rvalid = (r_rd_owner == OWN_CPU);
    assign o_aux_rvalid = (r_rd_owner == OWN_AUX);
    assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : r_cpu_rdata;
    assign o_aux_rdata  = o_aux_rvalid ? i_mem_rdata : r_aux_rdata;
    assign o_mem_addr   = w_cpu_gnt ? i_cpu_addr : w_aux_gnt ? i_aux_addr : '0;
    assign o_mem_wdata  = w_cpu_gnt ? i_cpu_wdata : w_aux_gnt ? i_aux_wdata : '0;
    assign o_mem_we     = (w_cpu_gnt && i_cpu_we) || (w_aux_gnt && i_aux_we);

endmodule
